wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and datapath width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: cycles flush is held after a redirect; legal range 1..7.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_memtoreg, in_ctrl_neg and in_ctrl_zero, each input, 1 bit: WB control bits from the EX/WB buffer.
REQ-006 SHALL have ports in_memdata and in_aluresult, each input, DATA_W bits: load data and ALU result.
REQ-007 SHALL have port in_rd, input, 6: destination register index.
REQ-008 SHALL have ports rs_addr and rt_addr, each input, 6: decode-stage read addresses.
REQ-009 SHALL have ports rs_data and rt_data, each output, DATA_W: read data.
REQ-010 SHALL have port pc_redirect, output, 1: one-cycle registered redirect pulse.
REQ-011 SHALL have port pc_target, output, DATA_W: registered redirect target.
REQ-012 SHALL have port flush, output, 1: squash request to upstream buffers.
REQ-013 SHALL have port commit_count, output, 16: committed-instruction counter.

Function
REQ-014 SHALL form wb_data = in_ctrl_memtoreg ? in_memdata : in_aluresult.
REQ-015 SHALL contain 64 x DATA_W registers; all 64 are writable, including index 0.
REQ-016 SHALL write wb_data to register in_rd at posedge when in_ctrl_regwrt=1 and state=IDLE.
REQ-017 SHALL drive rs_data/rt_data combinationally; when the read address equals in_rd and a write is enabled this cycle, it SHALL return wb_data (write-through bypass).
REQ-018 SHALL compute take = in_ctrl_jump | (in_ctrl_branch & (in_ctrl_btype ? in_ctrl_neg : in_ctrl_zero)); btype 0 = branch-on-zero, btype 1 = branch-on-negative.
REQ-019 SHALL use a two-state FSM, IDLE and FLUSH, with a 3-bit down-counter.
REQ-020 In IDLE with take=1 at posedge: pc_redirect<=1, pc_target<=in_aluresult, counter<=FLUSH_CYCLES, state<=FLUSH; otherwise pc_redirect<=0.
REQ-021 The redirecting instruction's own register write SHALL still occur (REQ-016 is evaluated in IDLE).
REQ-022 In FLUSH: flush=1 (decoded from state), pc_redirect<=0, counter decrements each posedge; state<=IDLE when the counter decrements from 1 to 0.
REQ-023 In FLUSH, inputs are squashed: no register write, no redirect even if take=1, no commit count.
REQ-024 flush SHALL be 0 in IDLE; pc_target SHALL hold its value until the next redirect.
REQ-025 commit_count SHALL increment at posedge when state=IDLE and (regwrt|branch|jump)=1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-026 Latency: redirect becomes visible 1 cycle after the taken instruction is presented; flush is high for exactly FLUSH_CYCLES cycles immediately after that.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all registers to 0, state to IDLE, counter to 0, pc_redirect to 0, pc_target to 0 and commit_count to 0.
REQ-028 Reset asserted mid-FLUSH SHALL abort the flush immediately (flush=0 while rst_n=0 and after release).
REQ-029 The first posedge after rst_n rises SHALL be processed as IDLE.

Structure
REQ-030 A shared package SHALL hold DATA_W, REG_AW=6, BTYPE_ZERO=0, BTYPE_NEG=1 and the FSM state encoding.
REQ-031 The register array with its bypass SHALL be one sub-module, reg_file (2 read ports, 1 write port, async clear); wb_unit SHALL hold the FSM, the redirect registers and the counter.

Verification
REQ-032 Reset, then write r5 (regwrt=1, memtoreg=0, aluresult=0x1234) -> rs_addr=5 reads 0x1234 in the same cycle via bypass, and still reads 0x1234 after the edge.
REQ-033 memtoreg=1, memdata=0xDEADBEEF, aluresult=0x1, rd=63 -> r63=0xDEADBEEF; commit_count +1.
REQ-034 branch=1, btype=1, neg=1, aluresult=0x40 -> pc_redirect pulses 1 cycle with pc_target=0x40; flush=1 for exactly 2 cycles; regwrt/jump presented during those cycles cause no write, redirect or count.
REQ-035 branch=1, btype=0, zero=0, neg=1 -> no redirect, flush stays 0, commit_count +1.
REQ-036 Jump taken, then rst_n pulsed low during the first flush cycle -> flush=0 and pc_target=0 immediately; r0..r63 all read 0.
REQ-037 Preload commit_count to 0xFFFF via 65535 commits, then one more commit -> commit_count=0x0000.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// Shared definitions for the write-back unit: widths, branch-type encoding and FSM states.
package wb_unit_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 6;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int CNT_W = 3;

  localparam logic BTYPE_ZERO = 1'b0;
  localparam logic BTYPE_NEG  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/wb_unit_reg_file.sv
// 64-entry register file with two combinational read ports, one write port,
// write-through bypass and asynchronous clear of every entry.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);
  import wb_unit_pkg::*;

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A read that targets the entry being written this cycle sees the new value.
  assign o_rdata_a = (i_we && (i_raddr_a == i_waddr)) ? i_wdata : r_mem[i_raddr_a];
  assign o_rdata_b = (i_we && (i_raddr_b == i_waddr)) ? i_wdata : r_mem[i_raddr_b];

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: selects write-back data, writes the register file, resolves
// branches/jumps into a registered redirect and squashes upstream for a few cycles.
module wb_unit #(
  parameter int DATA_W       = wb_unit_pkg::DATA_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_ctrl_regwrt,
  input  logic              in_ctrl_branch,
  input  logic              in_ctrl_btype,
  input  logic              in_ctrl_jump,
  input  logic              in_ctrl_memtoreg,
  input  logic              in_ctrl_neg,
  input  logic              in_ctrl_zero,
  input  logic [DATA_W-1:0] in_memdata,
  input  logic [DATA_W-1:0] in_aluresult,
  input  logic [5:0]        in_rd,
  input  logic [5:0]        rs_addr,
  input  logic [5:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic [15:0]       commit_count
);
  import wb_unit_pkg::*;

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pc_redirect;
  logic [DATA_W-1:0] r_pc_target;
  logic [15:0]       r_commit_count;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_idle;
  logic              w_we;
  logic              w_take;
  logic              w_commit;

  assign w_wb_data = in_ctrl_memtoreg ? in_memdata : in_aluresult;
  assign w_idle    = (r_state == IDLE);
  assign w_we      = in_ctrl_regwrt && w_idle;
  assign w_take    = in_ctrl_jump |
                     (in_ctrl_branch & ((in_ctrl_btype == BTYPE_NEG) ? in_ctrl_neg : in_ctrl_zero));
  assign w_commit  = in_ctrl_regwrt | in_ctrl_branch | in_ctrl_jump;

  reg_file #(
    .DATA_W (DATA_W),
    .AW     (REG_AW)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (in_rd),
    .i_wdata   (w_wb_data),
    .i_raddr_a (rs_addr),
    .i_raddr_b (rt_addr),
    .o_rdata_a (rs_data),
    .o_rdata_b (rt_data)
  );

  // While flushing, incoming instructions are squashed: nothing redirects or commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_pc_redirect  <= 1'b0;
      r_pc_target    <= '0;
      r_commit_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_commit) begin
            r_commit_count <= r_commit_count + 16'd1;
          end
          if (w_take) begin
            r_pc_redirect <= 1'b1;
            r_pc_target   <= in_aluresult;
            r_cnt         <= FLUSH_INIT;
            r_state       <= FLUSH;
          end else begin
            r_pc_redirect <= 1'b0;
          end
        end
        FLUSH: begin
          r_pc_redirect <= 1'b0;
          r_cnt         <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign flush        = (r_state == FLUSH);
  assign pc_redirect  = r_pc_redirect;
  assign pc_target    = r_pc_target;
  assign commit_count = r_commit_count;

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: directed scenarios plus random traffic, each cycle's
// expected outputs come from a behavioural model and are checked by a separate monitor.
module tb_wb_unit;

  localparam int DW       = 32;
  localparam int FLUSH_N  = 2;

  typedef struct packed {
    logic          rstn;
    logic          regwrt;
    logic          branch;
    logic          btype;
    logic          jump;
    logic          memtoreg;
    logic          neg;
    logic          zero;
    logic [DW-1:0] mem;
    logic [DW-1:0] alu;
    logic [5:0]    rd;
    logic [5:0]    rs;
    logic [5:0]    rt;
  } stim_t;

  typedef struct {
    string         tag;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic          flush;
    logic          redir;
    logic [DW-1:0] target;
    logic [15:0]   commit;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump;
  logic          in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero;
  logic [DW-1:0] in_memdata, in_aluresult;
  logic [5:0]    in_rd, rs_addr, rt_addr;
  logic [DW-1:0] rs_data, rt_data, pc_target;
  logic          pc_redirect, flush;
  logic [15:0]   commit_count;

  int testsRun    = 0;
  int testsFailed = 0;

  exp_t expQ[$];
  event probeEv;

  // Reference state: architectural registers, cycles of squash still owed,
  // the last redirect and the number of instructions committed so far.
  logic [DW-1:0] mRegs [64];
  int            mFlushLeft;
  logic          mRedirect;
  logic [DW-1:0] mTarget;
  logic [15:0]   mCommit;

  wb_unit #(
    .DATA_W       (DW),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_ctrl_regwrt   (in_ctrl_regwrt),
    .in_ctrl_branch   (in_ctrl_branch),
    .in_ctrl_btype    (in_ctrl_btype),
    .in_ctrl_jump     (in_ctrl_jump),
    .in_ctrl_memtoreg (in_ctrl_memtoreg),
    .in_ctrl_neg      (in_ctrl_neg),
    .in_ctrl_zero     (in_ctrl_zero),
    .in_memdata       (in_memdata),
    .in_aluresult     (in_aluresult),
    .in_rd            (in_rd),
    .rs_addr          (rs_addr),
    .rt_addr          (rt_addr),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .pc_redirect      (pc_redirect),
    .pc_target        (pc_target),
    .flush            (flush),
    .commit_count     (commit_count)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rstn = 1'b1;
    return s;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) mRegs[i] = '0;
    mFlushLeft = 0;
    mRedirect  = 1'b0;
    mTarget    = '0;
    mCommit    = '0;
  endfunction

  // What the outputs must show this cycle, given current reference state and inputs.
  function automatic exp_t computeExp(stim_t s, string tag);
    exp_t          e;
    logic [DW-1:0] wb;
    logic          writing;
    wb      = s.memtoreg ? s.mem : s.alu;
    writing = (mFlushLeft == 0) && s.regwrt;
    e.tag    = tag;
    e.rs     = (writing && s.rs == s.rd) ? wb : mRegs[s.rs];
    e.rt     = (writing && s.rt == s.rd) ? wb : mRegs[s.rt];
    e.flush  = (mFlushLeft != 0);
    e.redir  = mRedirect;
    e.target = mTarget;
    e.commit = mCommit;
    return e;
  endfunction

  // Effect of the clock edge that ends this cycle.
  function automatic void modelEdge(stim_t s);
    logic taken;
    if (mFlushLeft == 0) begin
      taken = s.jump || (s.branch && (s.btype ? s.neg : s.zero));
      if (s.regwrt) mRegs[s.rd] = s.memtoreg ? s.mem : s.alu;
      if (s.regwrt || s.branch || s.jump) mCommit = mCommit + 16'd1;
      mRedirect = taken;
      if (taken) begin
        mTarget    = s.alu;
        mFlushLeft = FLUSH_N;
      end
    end else begin
      mRedirect  = 1'b0;
      mFlushLeft = mFlushLeft - 1;
    end
  endfunction

  task automatic driveInputs(stim_t s);
    rst_n            = s.rstn;
    in_ctrl_regwrt   = s.regwrt;
    in_ctrl_branch   = s.branch;
    in_ctrl_btype    = s.btype;
    in_ctrl_jump     = s.jump;
    in_ctrl_memtoreg = s.memtoreg;
    in_ctrl_neg      = s.neg;
    in_ctrl_zero     = s.zero;
    in_memdata       = s.mem;
    in_aluresult     = s.alu;
    in_rd            = s.rd;
    rs_addr          = s.rs;
    rt_addr          = s.rt;
  endtask

  // One cycle: drive just after the edge, queue the expectation, advance the model.
  task automatic applyStimulus(stim_t s, string tag);
    @(posedge clk);
    #1;
    driveInputs(s);
    if (!s.rstn) modelReset();
    expQ.push_back(computeExp(s, tag));
    if (s.rstn) modelEdge(s);
  endtask

  task automatic compareField(string tag, string field, logic [DW-1:0] act, logic [DW-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(exp_t e);
    compareField(e.tag, "rs_data",      rs_data,            e.rs);
    compareField(e.tag, "rt_data",      rt_data,            e.rt);
    compareField(e.tag, "flush",        DW'(flush),         DW'(e.flush));
    compareField(e.tag, "pc_redirect",  DW'(pc_redirect),   DW'(e.redir));
    compareField(e.tag, "pc_target",    pc_target,          e.target);
    compareField(e.tag, "commit_count", DW'(commit_count),  DW'(e.commit));
  endtask

  // Monitor: pops one expectation per sample point (mid-cycle, or an asynchronous probe).
  initial begin
    forever begin
      @(negedge clk or probeEv);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Bound on total runtime so a stuck run still reports.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, random traffic, then the commit-counter wrap.
  initial begin
    stim_t s;
    modelReset();
    driveInputs('0);

    s = '0;
    applyStimulus(s, "reset0");
    applyStimulus(s, "reset1");

    s = idleStim(); s.regwrt = 1'b1; s.rd = 6'd5; s.alu = 32'h1234; s.rs = 6'd5; s.rt = 6'd6;
    applyStimulus(s, "bypass_r5");
    s = idleStim(); s.rs = 6'd5; s.rt = 6'd5;
    applyStimulus(s, "read_r5");

    s = idleStim(); s.regwrt = 1'b1; s.memtoreg = 1'b1; s.mem = 32'hDEADBEEF; s.alu = 32'h1;
    s.rd = 6'd63; s.rs = 6'd63;
    applyStimulus(s, "load_r63");
    s = idleStim(); s.rt = 6'd63;
    applyStimulus(s, "read_r63");

    s = idleStim(); s.branch = 1'b1; s.btype = 1'b1; s.neg = 1'b1; s.alu = 32'h40;
    applyStimulus(s, "br_neg_taken");
    for (int i = 0; i < FLUSH_N; i++) begin
      s = idleStim(); s.regwrt = 1'b1; s.jump = 1'b1; s.rd = 6'd9; s.alu = 32'h999; s.rs = 6'd9;
      applyStimulus(s, $sformatf("squash%0d", i));
    end
    s = idleStim(); s.rs = 6'd9;
    applyStimulus(s, "after_flush");

    s = idleStim(); s.branch = 1'b1; s.btype = 1'b0; s.zero = 1'b0; s.neg = 1'b1; s.alu = 32'h77;
    applyStimulus(s, "br_zero_not_taken");
    s = idleStim();
    applyStimulus(s, "after_not_taken");
    s = idleStim(); s.branch = 1'b1; s.btype = 1'b0; s.zero = 1'b1; s.alu = 32'h88;
    s.regwrt = 1'b1; s.rd = 6'd0; s.rs = 6'd0;
    applyStimulus(s, "br_zero_taken_wr_r0");
    s = idleStim();
    applyStimulus(s, "redirect_r0");

    for (int i = 0; i < 400; i++) begin
      s = idleStim();
      s.regwrt   = ($urandom_range(0, 3) != 0);
      s.branch   = ($urandom_range(0, 3) == 0);
      s.btype    = 1'($urandom);
      s.jump     = ($urandom_range(0, 15) == 0);
      s.memtoreg = 1'($urandom);
      s.neg      = 1'($urandom);
      s.zero     = 1'($urandom);
      s.mem      = $urandom;
      s.alu      = $urandom;
      s.rd       = 6'($urandom_range(0, 15));
      s.rs       = ($urandom_range(0, 3) == 0) ? s.rd : 6'($urandom_range(0, 15));
      s.rt       = 6'($urandom);
      applyStimulus(s, $sformatf("rand%0d", i));
    end

    s = idleStim(); s.jump = 1'b1; s.alu = 32'h80;
    applyStimulus(s, "jump_then_reset");
    s = idleStim(); s.regwrt = 1'b1; s.rd = 6'd7; s.alu = 32'h55; s.rs = 6'd1; s.rt = 6'd2;
    applyStimulus(s, "flush_cycle1");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    s.rstn = 1'b0;
    modelReset();
    expQ.push_back(computeExp(s, "async_reset_midflush"));
    #1;
    ->probeEv;
    for (int i = 0; i < 32; i++) begin
      s = idleStim();
      s.rstn = (i > 0);
      s.rs = 6'(2 * i);
      s.rt = 6'(2 * i + 1);
      applyStimulus(s, $sformatf("cleared_r%0d", 2 * i));
    end

    s = '0;
    applyStimulus(s, "reset_wrap");
    for (int i = 0; i < 65535; i++) begin
      s = idleStim(); s.branch = 1'b1; s.btype = 1'b0; s.zero = 1'b0;
      applyStimulus(s, "commit_fill");
    end
    s = idleStim(); s.branch = 1'b1; s.btype = 1'b0; s.zero = 1'b0;
    applyStimulus(s, "commit_ffff");
    s = idleStim();
    applyStimulus(s, "commit_wrapped");

    @(negedge clk);
    #2;
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
